// File: rtl/snn_fixed_pkg.sv
// Shared fixed-point helpers and state encoding for the spiking-neuron datapath.
// Values are signed Q16.16 in a 32-bit word; every arithmetic result clamps
// instead of wrapping.
package snn_fixed_pkg;

  localparam int DEF_N = 32;
  localparam int DEF_Q = 16;

  localparam logic [DEF_N-1:0] FX_ONE = 32'h0001_0000;
  localparam logic [DEF_N-1:0] FX_MAX = 32'h7FFF_FFFF;
  localparam logic [DEF_N-1:0] FX_MIN = 32'h8000_0000;

  // Bounds of the representable range, widened to the product width.
  localparam logic signed [2*DEF_N-1:0] MUL_HI = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [2*DEF_N-1:0] MUL_LO = 64'shFFFF_FFFF_8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECAY,
    ST_DRAIN,
    ST_ISSUE
  } syn_state_t;

  // Two's-complement add that clamps on overflow. Overflow can only happen
  // when both operands share a sign and the result's sign differs.
  function automatic logic [DEF_N-1:0] sat_add(input logic [DEF_N-1:0] a,
                                               input logic [DEF_N-1:0] b);
    logic [DEF_N-1:0] s;
    s = a + b;
    if ((a[DEF_N-1] == b[DEF_N-1]) && (s[DEF_N-1] != a[DEF_N-1])) begin
      s = a[DEF_N-1] ? FX_MIN : FX_MAX;
    end
    return s;
  endfunction

  // Fixed-point multiply: full-width signed product, arithmetic shift back
  // by the number of fractional bits, then clamp to the word range.
  function automatic logic [DEF_N-1:0] sat_mul(input logic [DEF_N-1:0] a,
                                               input logic [DEF_N-1:0] b,
                                               input int           q);
    logic signed [2*DEF_N-1:0] a_ext;
    logic signed [2*DEF_N-1:0] b_ext;
    logic signed [2*DEF_N-1:0] prod;
    logic signed [2*DEF_N-1:0] shifted;
    logic        [DEF_N-1:0]   res;
    a_ext   = $signed({{DEF_N{a[DEF_N-1]}}, a});
    b_ext   = $signed({{DEF_N{b[DEF_N-1]}}, b});
    prod    = a_ext * b_ext;
    shifted = prod >>> q;
    if (shifted > MUL_HI) begin
      res = FX_MAX;
    end else if (shifted < MUL_LO) begin
      res = FX_MIN;
    end else begin
      res = shifted[DEF_N-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small circular buffer holding weighted presynaptic events until the next
// simulation step folds them into the synaptic current. Writes are refused
// while full; reads are refused while empty.
module event_fifo
  import snn_fixed_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] wr_data,
  input  logic         pop,
  output logic [N-1:0] rd_data,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/synaptic_input_stage.sv
// Input stage in front of the Izhikevich core. Queues weighted spike events,
// keeps a decaying synaptic current g, and on every simulation tick decays g,
// folds in the events that were queued when the tick arrived, and hands
// i = g + i_bias to the core with a one-cycle apply strobe.
module synaptic_input_stage
  import snn_fixed_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int Q     = DEF_Q,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ev_valid,
  input  logic [N-1:0] ev_weight,
  output logic         ev_ready,
  input  logic         tick,
  input  logic [N-1:0] decay,
  input  logic [N-1:0] i_bias,
  output logic [N-1:0] i,
  output logic         apply,
  output logic         busy,
  output logic         overrun,
  output logic [N-1:0] g
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE_LEFT = (AW + 1)'(1);

  syn_state_t    state;
  syn_state_t    next_state;
  logic [AW:0]   k_cnt;
  logic          fifo_pop;
  logic [N-1:0]  fifo_rd;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  event_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (ev_valid),
    .wr_data (ev_weight),
    .pop     (fifo_pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ev_ready = !fifo_full;
  assign busy     = (state != ST_IDLE);

  // State register for the per-tick step sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Step sequencing and FIFO pop request; the drain stops after exactly the
  // number of events snapshotted at the tick, so later arrivals wait.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          next_state = ST_DECAY;
        end
      end
      ST_DECAY: begin
        next_state = (k_cnt != '0) ? ST_DRAIN : ST_ISSUE;
      end
      ST_DRAIN: begin
        fifo_pop = !fifo_empty;
        if (k_cnt == ONE_LEFT) begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Synaptic datapath: snapshot, decay, accumulate, and issue to the core.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g       <= '0;
      i       <= '0;
      apply   <= 1'b0;
      overrun <= 1'b0;
      k_cnt   <= '0;
    end else begin
      apply   <= 1'b0;
      overrun <= tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (tick) begin
            k_cnt <= fifo_count;
          end
        end
        ST_DECAY: begin
          g <= sat_mul(g, decay, Q);
        end
        ST_DRAIN: begin
          if (fifo_pop) begin
            g     <= sat_add(g, fifo_rd);
            k_cnt <= k_cnt - 1'b1;
          end
        end
        ST_ISSUE: begin
          i     <= sat_add(g, i_bias);
          apply <= 1'b1;
        end
        default: begin
          k_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synaptic_input_stage.sv
// Scoreboard bench for the synaptic input stage. The stimulus thread queues
// the expected current, synaptic state and strobe cycle for every tick; the
// monitor pops one entry per apply strobe and compares.
module tb_synaptic_input_stage;

  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] HALF = 32'h0000_8000;
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  typedef struct {
    logic [31:0] exp_i;
    logic [31:0] exp_g;
    int          exp_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ev_valid;
  logic [31:0] ev_weight;
  logic        ev_ready;
  logic        tick;
  logic [31:0] decay;
  logic [31:0] i_bias;
  logic [31:0] i;
  logic        apply;
  logic        busy;
  logic        overrun;
  logic [31:0] g;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   passes;
  int   tick_edge;

  synaptic_input_stage #(
    .N     (32),
    .Q     (16),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ev_valid  (ev_valid),
    .ev_weight (ev_weight),
    .ev_ready  (ev_ready),
    .tick      (tick),
    .decay     (decay),
    .i_bias    (i_bias),
    .i         (i),
    .apply     (apply),
    .busy      (busy),
    .overrun   (overrun),
    .g         (g)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time-stamp tick acceptance and apply strobes.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: each apply strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && apply) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_apply: got apply at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("apply_i", i, e.exp_i);
        checkOutput("apply_g", g, e.exp_g);
        checkOutput("apply_cycle", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  // Offer one event and hold it until the stage accepts it.
  task automatic pushEvent(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    ev_valid  = 1'b1;
    ev_weight = w;
    while (!ev_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) begin
      checks++;
      $display("[TB] FAIL push_timeout: got ev_ready=0, expected 1 within 40 cycles");
    end
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
  endtask

  // Issue one tick and queue the response expected k+2 edges later.
  task automatic applyStimulus(input int k, input logic [31:0] exp_i,
                               input logic [31:0] exp_g);
    exp_t e;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick      = 1'b0;
    tick_edge = cyc;
    e.exp_i   = exp_i;
    e.exp_g   = exp_g;
    e.exp_cyc = tick_edge + k + 2;
    sb.push_back(e);
  endtask

  // Wait, with a bound, for the monitor to consume every expectation.
  task automatic waitScoreboard();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("[TB] FAIL apply_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    rst       = 1'b0;
    ev_valid  = 1'b0;
    ev_weight = '0;
    tick      = 1'b0;
    decay     = ONE;
    i_bias    = '0;

    // Reset state.
    #2;
    checkOutput("reset_i", i, 32'h0);
    checkOutput("reset_g", g, 32'h0);
    checkOutput("reset_apply", 32'(apply), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_overrun", 32'(overrun), 32'h0);
    checkOutput("reset_ev_ready", 32'(ev_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Accumulate: 1.0 + 2.0 - 0.5 with unity decay.
    $display("[TB] accumulate");
    pushEvent(32'h0001_0000);
    pushEvent(32'h0002_0000);
    pushEvent(32'hFFFF_8000);
    applyStimulus(3, 32'h0002_8000, 32'h0002_8000);
    waitScoreboard();

    // Decay only: g halves, bias added on issue.
    $display("[TB] decay only");
    decay  = HALF;
    i_bias = 32'h0000_1000;
    applyStimulus(0, 32'h0001_5000, 32'h0001_4000);
    waitScoreboard();

    // Positive then negative saturation.
    $display("[TB] saturation");
    decay  = ONE;
    i_bias = '0;
    pushEvent(32'h7FFF_0000);
    pushEvent(32'h7FFF_0000);
    applyStimulus(2, SMAX, SMAX);
    waitScoreboard();
    pushEvent(SMIN);
    pushEvent(SMIN);
    applyStimulus(2, SMIN, SMIN);
    waitScoreboard();

    // FIFO full and tick snapshot: fifth event waits for the following tick.
    $display("[TB] fifo full");
    pushEvent(32'h2000_0000);
    pushEvent(32'h2000_0000);
    pushEvent(32'h2000_0000);
    pushEvent(32'h2001_0000);
    @(negedge clk);
    checkOutput("full_ev_ready", 32'(ev_ready), 32'h0);
    fork
      pushEvent(32'h0003_0000);
      applyStimulus(4, 32'h0001_0000, 32'h0001_0000);
    join
    waitScoreboard();
    checkOutput("left_queued", 32'(dut.u_fifo.count), 32'h1);
    applyStimulus(1, 32'h0004_0000, 32'h0004_0000);
    waitScoreboard();

    // Overrun: tick held for a second edge while the step is running.
    $display("[TB] overrun");
    decay = HALF;
    begin
      exp_t e;
      @(negedge clk);
      tick = 1'b1;
      @(posedge clk);
      @(negedge clk);
      e.exp_i   = 32'h0002_0000;
      e.exp_g   = 32'h0002_0000;
      e.exp_cyc = cyc + 2;
      sb.push_back(e);
      checkOutput("overrun_before", 32'(overrun), 32'h0);
      @(posedge clk);
      @(negedge clk);
      tick = 1'b0;
      checkOutput("overrun_pulse", 32'(overrun), 32'h1);
      @(negedge clk);
      checkOutput("overrun_after", 32'(overrun), 32'h0);
    end
    waitScoreboard();
    repeat (4) @(negedge clk);

    // Reset asserted asynchronously in the middle of a drain.
    $display("[TB] reset mid-drain");
    decay = ONE;
    pushEvent(32'h0001_0000);
    pushEvent(32'h0001_0000);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("drain_busy", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("async_busy", 32'(busy), 32'h0);
    checkOutput("async_apply", 32'(apply), 32'h0);
    checkOutput("async_i", i, 32'h0);
    checkOutput("async_g", g, 32'h0);
    checkOutput("async_ev_ready", 32'(ev_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("post_reset_i", i, 32'h0);
    checkOutput("post_reset_busy", 32'(busy), 32'h0);
    checkOutput("pending_expectations", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
